// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg: FSM state encoding and counter-width helper for serial_subtractor.
package serial_subtractor_pkg;
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    function automatic int clog2(input int n);
        for (int i = 1; i < 32; i++)
            if ((1 << i) >= n) return i;
        return 32;
    endfunction
endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// full_subtractor: combinational 1-bit cell, D = A - B - Bin with borrow-out.
module full_subtractor (
    input  logic A,
    input  logic B,
    input  logic Bin,
    output logic D,
    output logic Bout
);
    assign D    = A ^ B ^ Bin;
    assign Bout = (~A & B) | (~(A ^ B) & Bin);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial Diff = A - B - Bin, LSB first, one bit per clock.
// Defining SERIAL_SUBTRACTOR_OVF_EN adds the registered two's-complement overflow output V.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    output logic             V
`endif
);
    localparam int CW = clog2(WIDTH);

    state_t           r_state;
    logic [WIDTH-1:0] r_a, r_b, r_d;
    logic             r_br;
    logic [CW-1:0]    r_cnt;
    logic             w_d, w_bout;

    full_subtractor u_fs (
        .A   (r_a[0]),
        .B   (r_b[0]),
        .Bin (r_br),
        .D   (w_d),
        .Bout(w_bout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            Diff    <= '0;
            Bout    <= 1'b0;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_d     <= '0;
            r_br    <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            V       <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_a     <= A;
                    r_b     <= B;
                    r_br    <= Bin;
                    r_cnt   <= '0;
                    r_state <= S_SHIFT;
                    busy    <= 1'b1;
                end
                S_SHIFT: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_d   <= {w_d, r_d[WIDTH-1:1]};
                    r_br  <= w_bout;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        Diff    <= {w_d, r_d[WIDTH-1:1]};
                        Bout    <= w_bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                        // on the last bit r_a[0]/r_b[0] are the original operand MSBs
                        V       <= (r_a[0] != r_b[0]) && (w_d != r_a[0]);
`endif
                        r_state <= S_DONE;
                        done    <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end
endmodule
